// File: rtl/result_wb_pipe_if.sv
// result_wb_pipe_if: issue, result-delivery, forwarding and writeback bundle
// for one execution pipe's result_wb_pipe instance.
interface result_wb_pipe_if #(
   parameter int unsigned REG_DATA_WD = 128,
   parameter int unsigned ADDR_WD     = 7
);
   logic                   issue_vld;
   logic [ADDR_WD-1:0]     issue_rt_addr;
   logic [2:0]             issue_idx;
   logic                   flush;

   logic                   res_vld_l2, res_vld_l3, res_vld_l4, res_vld_l6, res_vld_l7;
   logic [REG_DATA_WD-1:0] res_data_l2, res_data_l3, res_data_l4, res_data_l6, res_data_l7;

   logic [ADDR_WD-1:0]     rf_addr_s2, rf_addr_s3, rf_addr_s4, rf_addr_s5, rf_addr_s6, rf_addr_s7;
   logic [REG_DATA_WD-1:0] rf_data_s2, rf_data_s3, rf_data_s4, rf_data_s5, rf_data_s6, rf_data_s7;
   logic [2:0]             rf_idx_s2, rf_idx_s3, rf_idx_s4, rf_idx_s5, rf_idx_s6, rf_idx_s7;

   logic                   rf_we_wb;
   logic [ADDR_WD-1:0]     rf_addr_wb;
   logic [REG_DATA_WD-1:0] rf_data_wb;
   logic                   err_missing;
   logic                   err_orphan;

   modport master (
      output issue_vld, issue_rt_addr, issue_idx, flush,
      output res_vld_l2, res_vld_l3, res_vld_l4, res_vld_l6, res_vld_l7,
      output res_data_l2, res_data_l3, res_data_l4, res_data_l6, res_data_l7,
      input  rf_addr_s2, rf_addr_s3, rf_addr_s4, rf_addr_s5, rf_addr_s6, rf_addr_s7,
      input  rf_data_s2, rf_data_s3, rf_data_s4, rf_data_s5, rf_data_s6, rf_data_s7,
      input  rf_idx_s2, rf_idx_s3, rf_idx_s4, rf_idx_s5, rf_idx_s6, rf_idx_s7,
      input  rf_we_wb, rf_addr_wb, rf_data_wb, err_missing, err_orphan
   );

   modport slave (
      input  issue_vld, issue_rt_addr, issue_idx, flush,
      input  res_vld_l2, res_vld_l3, res_vld_l4, res_vld_l6, res_vld_l7,
      input  res_data_l2, res_data_l3, res_data_l4, res_data_l6, res_data_l7,
      output rf_addr_s2, rf_addr_s3, rf_addr_s4, rf_addr_s5, rf_addr_s6, rf_addr_s7,
      output rf_data_s2, rf_data_s3, rf_data_s4, rf_data_s5, rf_data_s6, rf_data_s7,
      output rf_idx_s2, rf_idx_s3, rf_idx_s4, rf_idx_s5, rf_idx_s6, rf_idx_s7,
      output rf_we_wb, rf_addr_wb, rf_data_wb, err_missing, err_orphan
   );
endinterface

// File: rtl/result_wb_pipe.sv
// result_wb_pipe: carries issued destinations down s1..s7 into writeback,
// captures unit results at their fixed latency and publishes per-stage
// address/data/index for forwarding.
// Optional macro RESULT_WB_PIPE_CHECK_EN: adds got tracking plus sticky
// err_missing / err_orphan flags; without it writeback ignores delivery.
module result_wb_pipe #(
   parameter int unsigned REG_DATA_WD  = 128,
   parameter int unsigned ADDR_WD      = 7,
   parameter int unsigned FLUSH_STAGES = 3
) (
   input  logic            clk,
   input  logic            rst,
   result_wb_pipe_if.slave bus
);

   function automatic int unsigned lat_of(input logic [2:0] idx);
      case (idx)
         3'd1:    return 2;
         3'd2:    return 3;
         3'd3:    return 6;
         3'd4:    return 3;
         3'd5:    return 4;
         3'd6:    return 6;
         3'd7:    return 7;
         default: return 0;
      endcase
   endfunction

   logic [ADDR_WD-1:0]     addr_q [1:7];
   logic [2:0]             idx_q  [1:7];
   logic [REG_DATA_WD-1:0] data_q [1:7];
   logic [ADDR_WD-1:0]     addr_d [1:7];
   logic [2:0]             idx_d  [1:7];
   logic [REG_DATA_WD-1:0] data_d [1:7];

   logic [7:0]             vld_by_lat;
   logic [REG_DATA_WD-1:0] data_by_lat [0:7];
   logic [2:0]             src, dst;
   logic                   cap, kill;

   logic                   we_d, we_q;
   logic [ADDR_WD-1:0]     wb_addr_q;
   logic [REG_DATA_WD-1:0] wb_data_q;

`ifdef RESULT_WB_PIPE_CHECK_EN
   // kidx remembers the unit index of a flushed entry so its late result is
   // recognised as expected rather than orphaned
   logic                   got_q  [1:7];
   logic                   got_d  [1:7];
   logic [2:0]             kidx_q [1:7];
   logic [2:0]             kidx_d [1:7];
   logic                   missing_d, missing_q;
   logic                   orphan_d, orphan_q;
`endif

   // next-state of every stage: shift, latency-exact capture, flush kill
   always_comb begin
      vld_by_lat     = '0;
      vld_by_lat[2]  = bus.res_vld_l2;
      vld_by_lat[3]  = bus.res_vld_l3;
      vld_by_lat[4]  = bus.res_vld_l4;
      vld_by_lat[6]  = bus.res_vld_l6;
      vld_by_lat[7]  = bus.res_vld_l7;
      data_by_lat[0] = '0;
      data_by_lat[1] = '0;
      data_by_lat[2] = bus.res_data_l2;
      data_by_lat[3] = bus.res_data_l3;
      data_by_lat[4] = bus.res_data_l4;
      data_by_lat[5] = '0;
      data_by_lat[6] = bus.res_data_l6;
      data_by_lat[7] = bus.res_data_l7;
      src  = '0;
      dst  = '0;
      cap  = 1'b0;
      kill = 1'b0;

      addr_d[1] = '0;
      idx_d[1]  = '0;
      data_d[1] = '0;
      if (bus.issue_vld && !bus.flush) begin
         addr_d[1] = bus.issue_rt_addr;
         idx_d[1]  = bus.issue_idx;
      end
`ifdef RESULT_WB_PIPE_CHECK_EN
      got_d[1]  = 1'b0;
      kidx_d[1] = (bus.issue_vld && bus.flush) ? bus.issue_idx : '0;
      missing_d = missing_q;
      orphan_d  = orphan_q;
`endif

      for (int unsigned k = 1; k < 7; k++) begin
         src  = 3'(k);
         dst  = 3'(k + 1);
         cap  = (lat_of(idx_q[src]) == k + 1) && vld_by_lat[dst];
         kill = bus.flush && (k + 1 <= FLUSH_STAGES);
         addr_d[dst] = kill ? '0 : addr_q[src];
         idx_d[dst]  = kill ? '0 : idx_q[src];
         data_d[dst] = kill ? '0 : (cap ? data_by_lat[dst] : data_q[src]);
`ifdef RESULT_WB_PIPE_CHECK_EN
         got_d[dst]  = !kill && (got_q[src] || cap);
         kidx_d[dst] = (kill && idx_q[src] != '0) ? idx_q[src] : kidx_q[src];
         if (!kill && lat_of(idx_q[src]) == k + 1 && !vld_by_lat[dst])
            missing_d = 1'b1;
         if (vld_by_lat[dst] && lat_of(idx_q[src]) != k + 1 &&
             lat_of(kidx_q[src]) != k + 1)
            orphan_d = 1'b1;
`endif
      end

      we_d = (idx_q[7] != '0);
`ifdef RESULT_WB_PIPE_CHECK_EN
      we_d = we_d && got_q[7];
`endif
   end

   // stage and writeback registers
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q    <= '{default: '0};
         idx_q     <= '{default: '0};
         data_q    <= '{default: '0};
         we_q      <= 1'b0;
         wb_addr_q <= '0;
         wb_data_q <= '0;
      end else begin
         addr_q    <= addr_d;
         idx_q     <= idx_d;
         data_q    <= data_d;
         we_q      <= we_d;
         wb_addr_q <= we_d ? addr_q[7] : '0;
         wb_data_q <= we_d ? data_q[7] : '0;
      end
   end

`ifdef RESULT_WB_PIPE_CHECK_EN
   // delivery tracking and sticky error flags
   always_ff @(posedge clk) begin
      if (rst) begin
         got_q     <= '{default: 1'b0};
         kidx_q    <= '{default: '0};
         missing_q <= 1'b0;
         orphan_q  <= 1'b0;
      end else begin
         got_q     <= got_d;
         kidx_q    <= kidx_d;
         missing_q <= missing_d;
         orphan_q  <= orphan_d;
      end
   end

   assign bus.err_missing = missing_q;
   assign bus.err_orphan  = orphan_q;
`else
   assign bus.err_missing = 1'b0;
   assign bus.err_orphan  = 1'b0;
`endif

   assign bus.rf_addr_s2 = addr_q[2];
   assign bus.rf_addr_s3 = addr_q[3];
   assign bus.rf_addr_s4 = addr_q[4];
   assign bus.rf_addr_s5 = addr_q[5];
   assign bus.rf_addr_s6 = addr_q[6];
   assign bus.rf_addr_s7 = addr_q[7];
   assign bus.rf_data_s2 = data_q[2];
   assign bus.rf_data_s3 = data_q[3];
   assign bus.rf_data_s4 = data_q[4];
   assign bus.rf_data_s5 = data_q[5];
   assign bus.rf_data_s6 = data_q[6];
   assign bus.rf_data_s7 = data_q[7];
   assign bus.rf_idx_s2  = idx_q[2];
   assign bus.rf_idx_s3  = idx_q[3];
   assign bus.rf_idx_s4  = idx_q[4];
   assign bus.rf_idx_s5  = idx_q[5];
   assign bus.rf_idx_s6  = idx_q[6];
   assign bus.rf_idx_s7  = idx_q[7];
   assign bus.rf_we_wb   = we_q;
   assign bus.rf_addr_wb = wb_addr_q;
   assign bus.rf_data_wb = wb_data_q;

endmodule

// File: tb/tb_result_wb_pipe.sv
// tb_result_wb_pipe: directed scenarios for result_wb_pipe.
module tb_result_wb_pipe;
   localparam int unsigned DW = 128;
   localparam int unsigned AW = 7;
`ifdef RESULT_WB_PIPE_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   result_wb_pipe_if #(.REG_DATA_WD(DW), .ADDR_WD(AW)) bus ();

   result_wb_pipe #(.REG_DATA_WD(DW), .ADDR_WD(AW), .FLUSH_STAGES(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.issue_vld     = 1'b0;
      bus.issue_rt_addr = '0;
      bus.issue_idx     = '0;
      bus.flush         = 1'b0;
      bus.res_vld_l2 = 1'b0; bus.res_data_l2 = '0;
      bus.res_vld_l3 = 1'b0; bus.res_data_l3 = '0;
      bus.res_vld_l4 = 1'b0; bus.res_data_l4 = '0;
      bus.res_vld_l6 = 1'b0; bus.res_data_l6 = '0;
      bus.res_vld_l7 = 1'b0; bus.res_data_l7 = '0;
   endtask

   function automatic logic [AW-1:0] st_addr(input int k);
      case (k)
         2: return bus.rf_addr_s2;
         3: return bus.rf_addr_s3;
         4: return bus.rf_addr_s4;
         5: return bus.rf_addr_s5;
         6: return bus.rf_addr_s6;
         default: return bus.rf_addr_s7;
      endcase
   endfunction

   function automatic logic [DW-1:0] st_data(input int k);
      case (k)
         2: return bus.rf_data_s2;
         3: return bus.rf_data_s3;
         4: return bus.rf_data_s4;
         5: return bus.rf_data_s5;
         6: return bus.rf_data_s6;
         default: return bus.rf_data_s7;
      endcase
   endfunction

   function automatic logic [2:0] st_idx(input int k);
      case (k)
         2: return bus.rf_idx_s2;
         3: return bus.rf_idx_s3;
         4: return bus.rf_idx_s4;
         5: return bus.rf_idx_s5;
         6: return bus.rf_idx_s6;
         default: return bus.rf_idx_s7;
      endcase
   endfunction

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      tick();
      tick();
      for (int k = 2; k <= 7; k++) begin
         checks++;
         if (st_addr(k) !== '0 || st_data(k) !== '0 || st_idx(k) !== '0) begin
            errors++;
            $display("FAIL reset_s%0d: got addr=%0h data=%0h idx=%0h required 0", k, st_addr(k), st_data(k), st_idx(k));
         end
      end
      checks++;
      if ({bus.rf_we_wb, bus.rf_addr_wb, bus.rf_data_wb, bus.err_missing, bus.err_orphan} !== '0) begin
         errors++;
         $display("FAIL reset_wb: got we=%b addr=%0h data=%0h em=%b eo=%b required 0", bus.rf_we_wb, bus.rf_addr_wb, bus.rf_data_wb, bus.err_missing, bus.err_orphan);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_lat2();
      clear_inputs();
      bus.issue_vld = 1'b1; bus.issue_rt_addr = 7'd5; bus.issue_idx = 3'd1;
      tick();
      clear_inputs();
      bus.res_vld_l2 = 1'b1; bus.res_data_l2 = 128'hA5;
      tick();
      clear_inputs();
      checks++;
      if (bus.rf_addr_s2 !== 7'd5 || bus.rf_data_s2 !== 128'hA5 || bus.rf_idx_s2 !== 3'd1) begin
         errors++;
         $display("FAIL lat2_s2: got addr=%0h data=%0h idx=%0h required 5/a5/1", bus.rf_addr_s2, bus.rf_data_s2, bus.rf_idx_s2);
      end
      for (int i = 0; i < 5; i++) tick();
      checks++;
      if (bus.rf_we_wb !== 1'b0) begin
         errors++;
         $display("FAIL lat2_wb_early: got we=%b required 0", bus.rf_we_wb);
      end
      tick();
      checks++;
      if (bus.rf_we_wb !== 1'b1 || bus.rf_addr_wb !== 7'd5 || bus.rf_data_wb !== 128'hA5) begin
         errors++;
         $display("FAIL lat2_wb: got we=%b addr=%0h data=%0h required 1/5/a5", bus.rf_we_wb, bus.rf_addr_wb, bus.rf_data_wb);
      end
      tick();
   endtask

   task automatic test_lat6();
      clear_inputs();
      bus.issue_vld = 1'b1; bus.issue_rt_addr = 7'd9; bus.issue_idx = 3'd3;
      tick();
      clear_inputs();
      for (int k = 2; k <= 5; k++) begin
         tick();
         checks++;
         if (st_data(k) !== '0 || st_idx(k) !== 3'd3 || st_addr(k) !== 7'd9) begin
            errors++;
            $display("FAIL lat6_s%0d: got data=%0h idx=%0h addr=%0h required 0/3/9", k, st_data(k), st_idx(k), st_addr(k));
         end
      end
      bus.res_vld_l6 = 1'b1; bus.res_data_l6 = 128'h1234;
      tick();
      clear_inputs();
      checks++;
      if (bus.rf_data_s6 !== 128'h1234 || bus.rf_idx_s6 !== 3'd3) begin
         errors++;
         $display("FAIL lat6_s6: got data=%0h idx=%0h required 1234/3", bus.rf_data_s6, bus.rf_idx_s6);
      end
      tick();
      tick();
      checks++;
      if (bus.rf_we_wb !== 1'b1 || bus.rf_addr_wb !== 7'd9 || bus.rf_data_wb !== 128'h1234) begin
         errors++;
         $display("FAIL lat6_wb: got we=%b addr=%0h data=%0h required 1/9/1234", bus.rf_we_wb, bus.rf_addr_wb, bus.rf_data_wb);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic          exp_we;
      logic [AW-1:0] exp_addr;
      logic [DW-1:0] exp_data;
      for (int c = 0; c < 13; c++) begin
         clear_inputs();
         if (c < 4) begin
            bus.issue_vld     = 1'b1;
            bus.issue_rt_addr = 7'(c + 1);
            case (c)
               0: bus.issue_idx = 3'd1;
               1: bus.issue_idx = 3'd2;
               2: bus.issue_idx = 3'd5;
               default: bus.issue_idx = 3'd7;
            endcase
         end
         if (c == 1) begin bus.res_vld_l2 = 1'b1; bus.res_data_l2 = 128'h11; end
         if (c == 3) begin bus.res_vld_l3 = 1'b1; bus.res_data_l3 = 128'h22; end
         if (c == 5) begin bus.res_vld_l4 = 1'b1; bus.res_data_l4 = 128'h33; end
         if (c == 9) begin bus.res_vld_l7 = 1'b1; bus.res_data_l7 = 128'h44; end
         tick();
         exp_we = 1'b0; exp_addr = '0; exp_data = '0;
         if (c >= 7 && c <= 10) begin
            exp_we   = 1'b1;
            exp_addr = 7'(c - 6);
            exp_data = 128'((c - 6) * 17);
         end
         checks++;
         if (bus.rf_we_wb !== exp_we || bus.rf_addr_wb !== exp_addr || bus.rf_data_wb !== exp_data) begin
            errors++;
            $display("FAIL b2b_wb_c%0d: got we=%b addr=%0h data=%0h required %b/%0h/%0h", c, bus.rf_we_wb, bus.rf_addr_wb, bus.rf_data_wb, exp_we, exp_addr, exp_data);
         end
      end
      clear_inputs();
      checks++;
      if (bus.err_missing !== 1'b0 || bus.err_orphan !== 1'b0) begin
         errors++;
         $display("FAIL b2b_err: got em=%b eo=%b required 0/0", bus.err_missing, bus.err_orphan);
      end
   endtask

   task automatic test_flush();
      logic          exp_we;
      logic [AW-1:0] exp_addr;
      logic [DW-1:0] exp_data;
      for (int c = 0; c < 12; c++) begin
         clear_inputs();
         if (c == 0) begin bus.issue_vld = 1'b1; bus.issue_rt_addr = 7'd6; bus.issue_idx = 3'd1; end
         if (c == 1) begin bus.res_vld_l2 = 1'b1; bus.res_data_l2 = 128'h66; end
         if (c == 3) begin bus.issue_vld = 1'b1; bus.issue_rt_addr = 7'd7; bus.issue_idx = 3'd4; end
         if (c == 4) begin
            bus.flush = 1'b1;
            bus.issue_vld = 1'b1; bus.issue_rt_addr = 7'd8; bus.issue_idx = 3'd1;
         end
         if (c == 5) begin
            bus.res_vld_l3 = 1'b1; bus.res_data_l3 = 128'hBEEF;
            bus.res_vld_l2 = 1'b1; bus.res_data_l2 = 128'hCAFE;
         end
         tick();
         if (c == 4) begin
            checks++;
            if (bus.rf_idx_s2 !== 3'd0 || bus.rf_addr_s2 !== 7'd0) begin
               errors++;
               $display("FAIL flush_s2: got idx=%0h addr=%0h required 0/0", bus.rf_idx_s2, bus.rf_addr_s2);
            end
            checks++;
            if (bus.rf_idx_s5 !== 3'd1 || bus.rf_addr_s5 !== 7'd6 || bus.rf_data_s5 !== 128'h66) begin
               errors++;
               $display("FAIL flush_s5_kept: got idx=%0h addr=%0h data=%0h required 1/6/66", bus.rf_idx_s5, bus.rf_addr_s5, bus.rf_data_s5);
            end
         end
         if (c == 5) begin
            checks++;
            if (bus.rf_idx_s2 !== 3'd0) begin
               errors++;
               $display("FAIL flush_drop_issue: got s2 idx=%0h required 0", bus.rf_idx_s2);
            end
         end
         exp_we = (c == 7);
         exp_addr = exp_we ? 7'd6 : '0;
         exp_data = exp_we ? 128'h66 : '0;
         checks++;
         if (bus.rf_we_wb !== exp_we || bus.rf_addr_wb !== exp_addr || bus.rf_data_wb !== exp_data) begin
            errors++;
            $display("FAIL flush_wb_c%0d: got we=%b addr=%0h data=%0h required %b/%0h/%0h", c, bus.rf_we_wb, bus.rf_addr_wb, bus.rf_data_wb, exp_we, exp_addr, exp_data);
         end
      end
      checks++;
      if (bus.err_missing !== 1'b0 || bus.err_orphan !== 1'b0) begin
         errors++;
         $display("FAIL flush_err: got em=%b eo=%b required 0/0", bus.err_missing, bus.err_orphan);
      end
   endtask

   task automatic test_errors();
      clear_inputs();
      bus.issue_vld = 1'b1; bus.issue_rt_addr = 7'd3; bus.issue_idx = 3'd2;
      tick();
      clear_inputs();
      tick();
      checks++;
      if (bus.err_missing !== 1'b0) begin
         errors++;
         $display("FAIL missing_early: got %b required 0", bus.err_missing);
      end
      tick();
      checks++;
      if (bus.err_missing !== CHK) begin
         errors++;
         $display("FAIL missing_set: got %b required %b", bus.err_missing, CHK);
      end
      for (int i = 0; i < 5; i++) tick();
      checks++;
      if (bus.rf_we_wb !== !CHK || bus.rf_addr_wb !== (CHK ? 7'd0 : 7'd3) || bus.rf_data_wb !== '0) begin
         errors++;
         $display("FAIL missing_wb: got we=%b addr=%0h data=%0h required %b/%0h/0", bus.rf_we_wb, bus.rf_addr_wb, bus.rf_data_wb, !CHK, CHK ? 0 : 3);
      end
      checks++;
      if (bus.err_missing !== CHK || bus.err_orphan !== 1'b0) begin
         errors++;
         $display("FAIL missing_sticky: got em=%b eo=%b required %b/0", bus.err_missing, bus.err_orphan, CHK);
      end
      bus.res_vld_l7 = 1'b1; bus.res_data_l7 = 128'h77;
      tick();
      clear_inputs();
      checks++;
      if (bus.err_orphan !== CHK) begin
         errors++;
         $display("FAIL orphan_set: got %b required %b", bus.err_orphan, CHK);
      end
      tick();
   endtask

   task automatic test_reset_midstream();
      for (int c = 0; c < 5; c++) begin
         clear_inputs();
         if (c < 4) begin
            bus.issue_vld = 1'b1; bus.issue_rt_addr = 7'(c + 1); bus.issue_idx = 3'd1;
         end
         if (c >= 1) begin bus.res_vld_l2 = 1'b1; bus.res_data_l2 = 128'(c + 160); end
         if (c == 4) rst = 1'b1;
         tick();
      end
      clear_inputs();
      rst = 1'b0;
      for (int k = 2; k <= 7; k++) begin
         checks++;
         if (st_addr(k) !== '0 || st_data(k) !== '0 || st_idx(k) !== '0) begin
            errors++;
            $display("FAIL midrst_s%0d: got addr=%0h data=%0h idx=%0h required 0", k, st_addr(k), st_data(k), st_idx(k));
         end
      end
      checks++;
      if ({bus.rf_we_wb, bus.rf_addr_wb, bus.rf_data_wb, bus.err_missing, bus.err_orphan} !== '0) begin
         errors++;
         $display("FAIL midrst_wb: got we=%b addr=%0h data=%0h em=%b eo=%b required 0", bus.rf_we_wb, bus.rf_addr_wb, bus.rf_data_wb, bus.err_missing, bus.err_orphan);
      end
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (bus.rf_we_wb !== 1'b0) begin
            errors++;
            $display("FAIL midrst_no_wb_%0d: got we=%b required 0", i, bus.rf_we_wb);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      test_reset();
      test_lat2();
      test_lat6();
      test_back_to_back();
      test_flush();
      test_errors();
      test_reset_midstream();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
